// File: rtl/wb_commit_queue.sv
// wb_commit_queue: in-order register-file write-back queue with forwarding lookups
module wb_commit_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [31:0]               Instruction,
    input  logic [DATA_W-1:0]         ALU_result,
    input  logic [DATA_W-1:0]         mem_data,
    input  logic [DATA_W-1:0]         opcplus4,
    input  logic                      RegWrite,
    input  logic                      MemtoReg,
    input  logic                      RegDst,
    input  logic                      Jal,
    output logic                      wr_valid,
    input  logic                      wr_ready,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [DATA_W-1:0]         wr_data,
    input  logic [ADDR_W-1:0]         fwd_addr_a,
    output logic                      fwd_hit_a,
    output logic [DATA_W-1:0]         fwd_data_a,
    input  logic [ADDR_W-1:0]         fwd_addr_b,
    output logic                      fwd_hit_b,
    output logic [DATA_W-1:0]         fwd_data_b,
    output logic [$clog2(DEPTH):0]    pending
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  vld;
    logic [PW-1:0]     wp, rp;
    logic [CW-1:0]     cnt;
    logic [ADDR_W-1:0] res_addr;
    logic [DATA_W-1:0] res_data;
    logic              push, pop;
    logic              unused_ins;

    assign unused_ins = ^{Instruction[31:21], Instruction[10:0]};

    // Resolve destination and data of the incoming request; link writes take priority
    always_comb begin
        res_addr = Jal ? ADDR_W'(31) : RegDst ? ADDR_W'(Instruction[15:11]) : ADDR_W'(Instruction[20:16]);
        res_data = Jal ? opcplus4 : MemtoReg ? mem_data : ALU_result;
    end

    // Handshakes; full blocks input regardless of a same-cycle pop, and writes to r0 are dropped
    always_comb begin
        in_ready = cnt < CW'(DEPTH);
        wr_valid = cnt != '0;
        push     = in_valid && in_ready && RegWrite && res_addr != '0;
        pop      = wr_valid && wr_ready;
        wr_addr  = wr_valid ? addr_q[rp] : '0;
        wr_data  = wr_valid ? data_q[rp] : '0;
        pending  = cnt;
    end

    // Entry payload storage; contents only matter while the matching valid bit is set
    always_ff @(posedge clock) begin
        if (push) begin
            addr_q[wp] <= res_addr;
            data_q[wp] <= res_data;
        end
    end

    // Pointers, occupancy and valid bits
    always_ff @(posedge clock) begin
        if (reset) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
            vld <= '0;
        end else begin
            if (pop) begin
                vld[rp] <= 1'b0;
                rp      <= rp + 1'b1;
            end
            if (push) begin
                vld[wp] <= 1'b1;
                wp      <= wp + 1'b1;
            end
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    // Walk entries oldest to youngest so the youngest match is the one that sticks
    function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] a);
        logic [DATA_W:0] r;
        logic [PW-1:0]   idx;
        r = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rp + PW'(i);
            if (a != '0 && vld[idx] && addr_q[idx] == a) r = {1'b1, data_q[idx]};
        end
        return r;
    endfunction

    // Forwarding lookups for decode's two source operands
    always_comb begin
        {fwd_hit_a, fwd_data_a} = lookup(fwd_addr_a);
        {fwd_hit_b, fwd_data_b} = lookup(fwd_addr_b);
    end
endmodule

// File: tb/tb_wb_commit_queue.sv
// tb_wb_commit_queue: scoreboard bench with a queue-based reference model
module tb_wb_commit_queue;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] Instruction = '0;
    logic [31:0] ALU_result = '0;
    logic [31:0] mem_data = '0;
    logic [31:0] opcplus4 = '0;
    logic        RegWrite = 1'b0;
    logic        MemtoReg = 1'b0;
    logic        RegDst = 1'b0;
    logic        Jal = 1'b0;
    logic        wr_valid;
    logic        wr_ready = 1'b0;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  fwd_addr_a = '0;
    logic        fwd_hit_a;
    logic [31:0] fwd_data_a;
    logic [4:0]  fwd_addr_b = '0;
    logic        fwd_hit_b;
    logic [31:0] fwd_data_b;
    logic [2:0]  pending;

    wb_commit_queue #(.DEPTH(DEPTH), .ADDR_W(5), .DATA_W(32)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .Instruction(Instruction), .ALU_result(ALU_result), .mem_data(mem_data),
        .opcplus4(opcplus4), .RegWrite(RegWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .Jal(Jal), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .fwd_addr_a(fwd_addr_a), .fwd_hit_a(fwd_hit_a),
        .fwd_data_a(fwd_data_a), .fwd_addr_b(fwd_addr_b), .fwd_hit_b(fwd_hit_b),
        .fwd_data_b(fwd_data_b), .pending(pending)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t mq[$];
    ent_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", n, act, req);
        end
    endtask

    function automatic logic [32:0] mfwd(input logic [4:0] a);
        logic [32:0] r;
        r = '0;
        if (a != 0)
            foreach (mq[i])
                if (mq[i].a == a) r = {1'b1, mq[i].d};
        return r;
    endfunction

    // Reference model: spec rules applied to a plain queue of pending writes
    always @(posedge clock) begin
        ent_t e;
        bit   popm, acc;
        if (reset) begin
            mq.delete();
            sb.delete();
        end else begin
            e.a  = Jal ? 5'd31 : RegDst ? Instruction[15:11] : Instruction[20:16];
            e.d  = Jal ? opcplus4 : MemtoReg ? mem_data : ALU_result;
            popm = mq.size() != 0 && wr_ready;
            acc  = in_valid && mq.size() < DEPTH && RegWrite && e.a != 0;
            if (popm) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(e);
                sb.push_back(e);
            end
        end
    end

    // Monitor: compares occupancy, handshakes, forwarding and every committed write
    always @(negedge clock) begin
        logic [32:0] fa, fb;
        ent_t        x;
        if (mon_en) begin
            fa = mfwd(fwd_addr_a);
            fb = mfwd(fwd_addr_b);
            chk("pending", 32'(pending), 32'(mq.size()));
            chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
            chk("wr_valid", 32'(wr_valid), 32'(mq.size() != 0));
            chk("fwd_hit_a", 32'(fwd_hit_a), 32'(fa[32]));
            chk("fwd_data_a", fwd_data_a, fa[31:0]);
            chk("fwd_hit_b", 32'(fwd_hit_b), 32'(fb[32]));
            chk("fwd_data_b", fwd_data_b, fb[31:0]);
            if (wr_valid && wr_ready) begin
                if (sb.size() == 0) chk("commit_unexpected", 32'(1), 32'(0));
                else begin
                    x = sb.pop_front();
                    chk("commit_addr", 32'(wr_addr), 32'(x.a));
                    chk("commit_data", wr_data, x.d);
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic req(input logic rw, input logic m2r, input logic rdst, input logic jal,
                       input logic [31:0] ins, input logic [31:0] alu,
                       input logic [31:0] mem, input logic [31:0] pc4);
        in_valid = 1'b1; RegWrite = rw; MemtoReg = m2r; RegDst = rdst; Jal = jal;
        Instruction = ins; ALU_result = alu; mem_data = mem; opcplus4 = pc4;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] ins;
        idle(2);
        reset = 1'b0;
        mon_en = 1'b1;
        @(negedge clock);
        chk("rst_wr_addr", 32'(wr_addr), 32'(0));
        chk("rst_wr_data", wr_data, 32'(0));
        chk("rst_pending", 32'(pending), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        step();
        // R-type write to rd=8
        wr_ready = 1'b1;
        req(1, 0, 1, 0, 32'h012A4020, 32'h1234, 32'h0, 32'h0);
        @(negedge clock);
        chk("rtype_valid", 32'(wr_valid), 32'(1));
        chk("rtype_addr", 32'(wr_addr), 32'(8));
        chk("rtype_data", wr_data, 32'h1234);
        step();
        idle(1);
        // load to rt=9 then jal link
        req(1, 1, 0, 0, 32'h8C090000, 32'h0, 32'hDEADBEEF, 32'h0);
        req(1, 0, 0, 1, 32'h0C000010, 32'h5555, 32'h0, 32'h40);
        idle(3);
        // dropped requests: no RegWrite, and destination r0
        req(0, 0, 1, 0, 32'h00004000, 32'h77, 32'h0, 32'h0);
        req(1, 0, 0, 0, 32'h00000000, 32'h88, 32'h0, 32'h0);
        idle(2);
        // fill under stall, fifth request must be refused
        wr_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            req(1, 0, 1, 0, 32'((10 + i) << 11), 32'(32'hA0 + i), 32'h0, 32'h0);
        @(negedge clock);
        chk("full_pending", 32'(pending), 32'(4));
        chk("full_in_ready", 32'(in_ready), 32'(0));
        chk("full_head_addr", 32'(wr_addr), 32'(10));
        chk("full_head_data", wr_data, 32'hA0);
        step();
        idle(2);
        wr_ready = 1'b1;
        idle(6);
        // youngest match wins for duplicate destinations
        wr_ready = 1'b0;
        req(1, 0, 1, 0, 32'(5 << 11), 32'h11, 32'h0, 32'h0);
        req(1, 0, 1, 0, 32'(5 << 11), 32'h22, 32'h0, 32'h0);
        fwd_addr_a = 5'd5;
        fwd_addr_b = 5'd0;
        @(negedge clock);
        chk("dup_hit_a", 32'(fwd_hit_a), 32'(1));
        chk("dup_data_a", fwd_data_a, 32'h22);
        chk("dup_hit_b", 32'(fwd_hit_b), 32'(0));
        step();
        wr_ready = 1'b1;
        idle(4);
        // reset with entries pending
        wr_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            req(1, 0, 1, 0, 32'((5 + i) << 11), 32'(32'hC0 + i), 32'h0, 32'h0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clock);
        chk("midrst_pending", 32'(pending), 32'(0));
        chk("midrst_wr_valid", 32'(wr_valid), 32'(0));
        chk("midrst_hit_a", 32'(fwd_hit_a), 32'(0));
        step();
        // randomized traffic across many pointer wraps
        for (int c = 0; c < 600; c++) begin
            ins = $urandom;
            ins[20:16] = 5'($urandom_range(0, 7));
            ins[15:11] = 5'($urandom_range(0, 7));
            in_valid    = ($urandom % 4) != 0;
            Instruction = ins;
            ALU_result  = $urandom;
            mem_data    = $urandom;
            opcplus4    = $urandom;
            RegWrite    = ($urandom % 8) != 0;
            MemtoReg    = $urandom % 2;
            RegDst      = $urandom % 2;
            Jal         = ($urandom % 8) == 0;
            wr_ready    = ($urandom % 3) != 0;
            fwd_addr_a  = ($urandom % 8 == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            fwd_addr_b  = ($urandom % 8 == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            reset       = ($urandom % 200) == 0;
            step();
        end
        reset = 1'b0;
        wr_ready = 1'b1;
        idle(DEPTH + 4);
        chk("drained", 32'(sb.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
